div_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder unit; the responder side of the decoder's divReady/PCHold stall handshake.
- The decoder raises PCHold while a div/divu/rem/remu instruction is in execute and divReady=0.
- div_unit runs a radix-2 restoring division, then pulses divReady with the result, so the decoder releases the PC and the ALU write-back captures the result.

---
 rtl/div_unit_pkg.sv | 35 +++
 rtl/div_unit_step.sv | 28 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: ALU op encodings,
// op field constants, FSM state type and special-case result constants.
package div_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [4:0] ALUC_DIV  = 5'b10100;
  localparam logic [4:0] ALUC_DIVU = 5'b10101;
  localparam logic [4:0] ALUC_REM  = 5'b10110;
  localparam logic [4:0] ALUC_REMU = 5'b10111;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  localparam logic [31:0] ALL_ONES_32 = '1;
  localparam logic [31:0] INT_MIN_32  = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  // op[0]=0 selects the signed variants (div/rem); op[1]=1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference when no borrow occurs.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M div/divu/rem/remu unit. Answers the decoder's PCHold stall
// with a one-cycle divReady pulse carrying the result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            divReady,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            sgn;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] step_rem, step_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    sgn   = op_is_signed(op);
    a_abs = (sgn && a[XLEN-1]) ? -a : a;
    b_abs = (sgn && b[XLEN-1]) ? -b : b;
  end

  always_comb begin
    state_d  = state_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d = op_is_rem(op);
          qneg_d   = sgn & (a[XLEN-1] ^ b[XLEN-1]);
          rneg_d   = sgn & a[XLEN-1];
          dvsr_d   = b_abs;
          quo_d    = a_abs;
          rem_d    = '0;
          cnt_d    = '0;
          // Division by zero and signed overflow skip the iteration loop.
          if (b == '0) begin
            result_d = op_is_rem(op) ? a : '1;
            state_d  = S_DONE;
          end else if (sgn && (a == INT_MIN) && (b == '1)) begin
            result_d = op_is_rem(op) ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            if (is_rem_q) result_d = rneg_q ? -step_rem : step_rem;
            else          result_d = qneg_q ? -step_quo : step_quo;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign divReady = (state_q == S_DONE);
  assign busy     = (state_q == S_CALC);
  assign result   = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit: expected result/latency queued on
// drive, popped and checked when divReady pulses.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int MAX_WAIT = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b;
  logic            divReady;
  logic [XLEN-1:0] result;
  logic            busy;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .divReady (divReady),
    .result   (result),
    .busy     (busy)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one op (called #1 after a posedge). Operands are scrambled mid-run
  // to show they are ignored after accept. Consumes the edge after the pulse.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int exp_lat, input bit keep,
                       input string tag);
    exp_t e;
    int cycles;
    exp_q.push_back('{res: exp_res, lat: exp_lat, tag: tag});
    op = o; a = x; b = y; start = 1'b1;
    cycles = 0;
    while (cycles <= MAX_WAIT) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 10) begin
        a = ~a;
        b = b + 32'd5;
      end
      if (divReady) break;
    end
    e = exp_q.pop_front();
    check32({e.tag, "_latency"}, cycles, e.lat);
    check32({e.tag, "_result"}, result, e.res);
    if (!keep) start = 1'b0;
    @(posedge clk); #1;
    check32({e.tag, "_pulse_width"}, {31'd0, divReady}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = OP_DIVU; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_divReady", {31'd0, divReady}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_result", result, 32'd0);
    rst = 1'b0;

    // Reset asserted mid-CALC: must return to IDLE with no pulse.
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (divReady) pulses++;
    end
    check32("midcalc_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_result", result, 32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (divReady) pulses++;
    end
    check32("rst_no_pulse", pulses, 32'd0);

    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0, "divu_100_7");
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0, "remu_100_7");
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, "div_m7_2");
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, "rem_m7_2");
    do_op(OP_DIVU, 32'd7, 32'hFFFF_FFFE, 32'd0, 33, 1'b0, "divu_7_big");
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, "div_7_m2");
    do_op(OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 1'b0, "rem_m7_m2");
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0, "divu_max_1");
    do_op(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0, "div_min_2");
    do_op(OP_DIV, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by_zero");
    do_op(OP_REM, 32'd123, 32'd0, 32'd123, 1, 1'b0, "rem_by_zero");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, "rem_ovf");

    // Back-to-back with start held: next accept follows the IDLE cycle after DONE.
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1, "b2b_first");
    do_op(OP_DIV, 32'd9, 32'd3, 32'd3, 33, 1'b0, "b2b_second");

    check32("result_holds", result, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
